// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: queues operand pairs in a 4-deep FIFO, issues one pair
// at a time to an external combinational adder and registers the returned
// sum and NaN flag behind a valid/ready output handshake.
// Optional feature: define FPU_NAN_COUNT_EN to add a saturating 8-bit count
// of NaN results on output nan_count.
module fpu_add_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic [31:0] add_A,
  output logic [31:0] add_B,
  input  logic [31:0] add_Result,
  input  logic        add_NaN_error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_Result,
  output logic        out_NaN,
  output logic        busy
`ifdef FPU_NAN_COUNT_EN
  ,
  output logic [7:0]  nan_count
`endif
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t      state, state_nxt;
  pair_t       fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        push, pop, capture;
  logic        fifo_nempty;

  assign fifo_nempty = (count != 3'd0);
  assign in_ready    = (count < 3'd4) && !rst;
  assign push        = in_valid && in_ready;
  assign busy        = (state != IDLE) || fifo_nempty;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one cycle in EVAL for the adder to settle, then HOLD until consumed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_nempty) state_nxt = EVAL;
      EVAL:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = fifo_nempty ? EVAL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: pop the head when starting a new evaluation, capture in EVAL
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE:    pop = fifo_nempty;
      EVAL:    capture = 1'b1;
      HOLD:    pop = out_ready && fifo_nempty;
      default: ;
    endcase
  end

  // FIFO storage; contents are don't-care until written, so no reset needed
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{a: in_A, b: in_B};
  end

  // FIFO pointers and occupancy; simultaneous push and pop keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // Issue registers feeding the adder; only a pop changes them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_A <= 32'd0;
      add_B <= 32'd0;
    end else if (pop) begin
      add_A <= fifo_mem[rd_ptr].a;
      add_B <= fifo_mem[rd_ptr].b;
    end
  end

  // Output register: capture in EVAL, drop valid when the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_Result <= 32'd0;
      out_NaN    <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      out_Result <= add_Result;
      out_NaN    <= add_NaN_error;
    end else if (state == HOLD && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef FPU_NAN_COUNT_EN
  // Saturating count of NaN results seen at capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        nan_count <= 8'd0;
    else if (capture && add_NaN_error && nan_count != 8'hff) nan_count <= nan_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Bench for fpu_add_sequencer: a table-driven stand-in for Add_FPU, a queue
// of expected results filled at accept time, and a negedge compare process.
module tb_fpu_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_A, in_B;
  logic [31:0] add_A, add_B, add_Result;
  logic        add_NaN_error;
  logic        out_valid, out_ready, out_NaN, busy;
  logic [31:0] out_Result;
`ifdef FPU_NAN_COUNT_EN
  logic [7:0]  nan_count;
`endif

  always #5 clk = ~clk;

  fpu_add_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .add_A(add_A), .add_B(add_B),
    .add_Result(add_Result), .add_NaN_error(add_NaN_error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Result(out_Result), .out_NaN(out_NaN), .busy(busy)
`ifdef FPU_NAN_COUNT_EN
    , .nan_count(nan_count)
`endif
  );

  // Add_FPU stand-in: exact single-precision sums for the operand pairs used here
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] k;
    k = {a, b};
    if (is_nan(a) || is_nan(b)) return 32'h7fc00000;
    case (k)
      64'h4019999a_3f99999a: return 32'h40666666;
      64'h00000000_3f4ccccd: return 32'h3f4ccccd;
      64'h3f800000_3f800000: return 32'h40000000;
      64'h3f800000_00000000: return 32'h3f800000;
      64'h40000000_3f800000: return 32'h40400000;
      64'h40400000_3f800000: return 32'h40800000;
      64'h40800000_3f800000: return 32'h40a00000;
      64'h40a00000_3f800000: return 32'h40c00000;
      64'h40c00000_3f800000: return 32'h40e00000;
      default:               return 32'hdeadbeef;
    endcase
  endfunction

  assign add_Result    = fadd(add_A, add_B);
  assign add_NaN_error = is_nan(add_A) || is_nan(add_B);

  typedef struct { logic [31:0] r; logic n; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: results in order, held stable while stalled
  logic        hold_prev = 1'b0;
  logic [31:0] prev_r;
  logic        prev_n;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", 64'({out_valid, out_NaN, out_Result}), 64'({1'b1, prev_n, prev_r}));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", 64'(out_Result), 64'hffffffff_ffffffff);
        end else if (out_ready) begin
          check("result", 64'(out_Result), 64'(q[0].r));
          check("nan",    64'(out_NaN),    64'(q[0].n));
          void'(q.pop_front());
          delivered++;
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_r    = out_Result;
      prev_n    = out_NaN;
    end
  end

  // Offer a pair until accepted; returns cycles spent waiting
  task automatic push(input logic [31:0] a, input logic [31:0] b, output int waited);
    bit ok;
    ok = 0; waited = 0;
    in_valid = 1'b1; in_A = a; in_B = b;
    while (!ok && waited < 200) begin
      if (in_ready) begin
        ok = 1;
        q.push_back('{r: fadd(a, b), n: is_nan(a) || is_nan(b)});
      end else waited++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("push_timeout", 64'(waited), 64'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("drain_timeout", 64'(q.size() != 0 || busy), 64'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  bit rnd_done = 0;
  int w, c0, c1, d0;
  logic [31:0] s3a [6];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; out_ready = 1'b0;
    cyc(2);
    // reset state
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_add_A",     64'({add_A, add_B}), 64'd0);
    check("rst_out",       64'({out_NaN, out_Result}), 64'd0);
    rst = 1'b0; #1;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Scenario 1: latency
    out_ready = 1'b1;
    push(32'h4019999a, 32'h3f99999a, w);
    check("s1_valid_T", 64'(out_valid), 64'd0);
    cyc(1);
    check("s1_valid_T1", 64'(out_valid), 64'd0);
    cyc(1);
    check("s1_valid_T2", 64'(out_valid), 64'd1);
    check("s1_result_lit", 64'(out_Result), 64'h40666666);
    check("s1_nan_lit", 64'(out_NaN), 64'd0);
    wait_drain();

    // Scenario 2: back-to-back, order and 2-cycle spacing
    push(32'h00000000, 32'h3f4ccccd, w);
    push(32'h7fc00000, 32'h40fb3333, w);
    c0 = 0;
    while (!out_valid && c0 < 20) begin cyc(1); c0++; end
    check("s2_first_lit", 64'({out_NaN, out_Result}), 64'({1'b0, 32'h3f4ccccd}));
    c1 = c0;
    cyc(1); c1++;
    while (!out_valid && c1 < 40) begin cyc(1); c1++; end
    check("s2_spacing", 64'(c1 - c0), 64'd2);
    check("s2_second_nan_lit", 64'(out_NaN), 64'd1);
    wait_drain();

    // Scenario 3: stall with 6 offered, 5 fit
    s3a = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000};
    out_ready = 1'b0;
    d0 = delivered;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) push(s3a[i], 32'h00000000, w);
      else        push(s3a[i], 32'h3f800000, w);
      check("s3_accept_wait", 64'(w), 64'd0);
    end
    in_valid = 1'b1; in_A = s3a[5]; in_B = 32'h3f800000; #1;
    check("s3_full_in_ready", 64'(in_ready), 64'd0);
    cyc(2);
    check("s3_full_in_ready2", 64'(in_ready), 64'd0);
    check("s3_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    push(s3a[5], 32'h3f800000, w);
    wait_drain();
    check("s3_delivered", 64'(delivered - d0), 64'd6);

    // Scenario 4: reset in HOLD with 3 queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h3f800000, 32'h3f800000, w);
    check("s4_in_hold", 64'({out_valid, busy}), 64'b11);
    rst = 1'b1; #1;
    q.delete();
    check("s4_rst_valid", 64'(out_valid), 64'd0);
    check("s4_rst_busy",  64'(busy), 64'd0);
    check("s4_rst_in_ready", 64'(in_ready), 64'd0);
    check("s4_rst_add", 64'({add_A, add_B}), 64'd0);
`ifdef FPU_NAN_COUNT_EN
    check("s4_rst_nan_count", 64'(nan_count), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("s4_in_ready_release", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    cyc(10);
    check("s4_no_results", 64'({out_valid, busy}), 64'd0);

    // Scenario 6: random out_ready while streaming 1+1
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          if (!rnd_done) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 10; i++) push(32'h3f800000, 32'h3f800000, w);
    wait_drain();
    rnd_done = 1;
    cyc(1);
    out_ready = 1'b1;

`ifdef FPU_NAN_COUNT_EN
    // Scenario 5: NaN count saturates
    for (int i = 0; i < 260; i++) push(32'h7fc00000, 32'h3f800000, w);
    wait_drain();
    check("s5_nan_count_sat", 64'(nan_count), 64'd255);
    cyc(3);
    check("s5_nan_count_hold", 64'(nan_count), 64'd255);
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_add_sequencer.md
FPU_ADD_SEQUENCER -- requirements
Module: fpu_add_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL present them as `clk` (input, 1) and `rst` (input, 1).
REQ-002 `in_valid`  input  1  operand pair offered.
REQ-003 `in_ready`  output  1  block can accept the offered pair.
REQ-004 `in_A`, `in_B`  input  32 each  IEEE-754 single-precision operands.
REQ-005 `add_A`, `add_B`  output  32 each  operands driven to the external combinational `Add_FPU` A/B ports.
REQ-006 `add_Result`  input  32  sum returned from `Add_FPU` Result.
REQ-007 `add_NaN_error`  input  1  NaN flag returned from `Add_FPU` NaN_error.
REQ-008 `out_valid`  output  1  result held in the output register.
REQ-009 `out_ready`  input  1  consumer accepts the result.
REQ-010 `out_Result`  output  32  registered sum.
REQ-011 `out_NaN`  output  1  registered NaN flag.
REQ-012 `busy`  output  1  high when the state is not IDLE or the FIFO is non-empty.

Function
REQ-013 Input transfer SHALL occur on a rising clk edge with `in_valid` && `in_ready`; the pair SHALL be written to a 4-entry FIFO in arrival order.
REQ-014 `in_ready` SHALL be combinational: FIFO count < 4 and `rst` low.
REQ-015 The FSM SHALL have exactly three states: IDLE, EVAL and HOLD.
REQ-016 IDLE: if the FIFO is non-empty, the block SHALL pop the head into the issue registers (`add_A`/`add_B`) and go to EVAL; otherwise it SHALL stay in IDLE.
REQ-017 EVAL (one cycle): at the next edge the block SHALL capture `add_Result`/`add_NaN_error` into `out_Result`/`out_NaN`, set `out_valid`=1 and go to HOLD.
REQ-018 HOLD: while `out_ready`=0 the block SHALL hold all outputs stable.
REQ-019 HOLD with `out_ready`=1: at the edge the block SHALL clear `out_valid`; if the FIFO is non-empty it SHALL pop into the issue registers and go to EVAL, else go to IDLE.
REQ-020 Latency: a pair accepted at edge T into an empty, idle block SHALL give `out_valid`=1 after edge T+2.
REQ-021 Throughput: with `out_ready` held high, the block SHALL produce one result per 2 cycles.
REQ-022 A push and a pop in the same cycle SHALL leave the FIFO count unchanged and lose no data.
REQ-023 A push is impossible when count = 4, so there SHALL be no overflow case.
REQ-024 Popping an empty FIFO SHALL never occur.
REQ-025 FIFO read and write pointers SHALL be 2 bits wide and wrap 3 -> 0.
REQ-026 `add_A`/`add_B` SHALL change only on a pop and SHALL otherwise hold their last value.
REQ-027 Results SHALL leave in the same order as operands entered.
REQ-028 The block SHALL perform no arithmetic on the data; it SHALL pass all 32 bits unmodified.

Reset
REQ-029 While `rst`=1, the block SHALL asynchronously force: FIFO count 0, pointers 0, state IDLE.
REQ-030 While `rst`=1, all of these outputs SHALL be 0: `add_A`, `add_B`, `out_valid`, `out_Result`, `out_NaN`, `busy`, `in_ready`.
REQ-031 A reset asserted mid-operation SHALL discard all queued and in-flight pairs; no result SHALL appear after release.
REQ-032 `in_ready` SHALL rise in the first cycle after `rst` is released.

Configuration
REQ-033 With macro `FPU_NAN_COUNT_EN` defined, the block SHALL add output `nan_count` [7:0].
REQ-034 `nan_count` SHALL increment by 1 on each EVAL capture where `add_NaN_error`=1, SHALL saturate at 255, and SHALL be reset to 0 by `rst`.
REQ-035 Without `FPU_NAN_COUNT_EN`, `nan_count` and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Bench setup: instantiate `Add_FPU` alongside the block.
REQ-037 Scenario 1: with `out_ready`=1, push 4019999a + 3f99999a -> `out_valid` after edge T+2, `out_Result`=40666666, `out_NaN`=0.
REQ-038 Scenario 2: push 00000000 + 3f4ccccd, then 7fc00000 + 40fb3333 back-to-back -> results in order: 3f4ccccd with `out_NaN`=0, then `out_NaN`=1; 2-cycle spacing.
REQ-039 Scenario 3: with `out_ready`=0, offer 6 pairs back-to-back -> first 5 accepted and `in_ready`=0 from the 6th; after raising `out_ready`, 6 results delivered in order with none lost.
REQ-040 Scenario 4: assert `rst` for 1 cycle while in HOLD with 3 pairs queued -> immediately `out_valid`=0, `busy`=0, `nan_count`=0; no further results; `in_ready`=1 the cycle after release.
REQ-041 Scenario 5 (`FPU_NAN_COUNT_EN`): push 260 NaN pairs -> `nan_count` reaches 255 and holds there.
REQ-042 Scenario 6: toggle `out_ready` randomly while pushing 3f800000 + 3f800000 -> every `out_Result`=40000000, and outputs stay stable whenever `out_valid`=1 and `out_ready`=0.
